mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one single-port synchronous RAM between
//  two requesters (A, B). Accepts read/write commands and drives the RAM command bus
//  with registered outputs. Returns read data to the winning requester.
//  Sits between the requester masters and the memory designs.
// PARAMETERS
//  SIZE        8                 number of memory words
//  WIDTH_DATA  8                 data width, bits
//  WIDTH_ADDR  $clog2(SIZE)      address width, bits (1..32; may exceed $clog2(SIZE))
// PORTS
//  clk        in   1           single clock; all logic on rising edge
//  rst_n      in   1           synchronous, active-low reset
//  req_a      in   1           A command request; hold with fields stable until gnt_a
//  we_a       in   1           A: 1=write, 0=read
//  addr_a     in   WIDTH_ADDR  A address
//  wdata_a    in   WIDTH_DATA  A write data
//  gnt_a      out  1           A command accepted (1-cycle pulse)
//  rvalid_a   out  1           A read data valid (1-cycle pulse)
//  rdata_a    out  WIDTH_DATA  A read data, valid when rvalid_a=1
//  err_a      out  1           A command rejected (see CONFIGURATION)
//  req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b, err_b : same for B
//  mem_en     out  1           RAM access strobe
//  mem_we     out  1           RAM write enable
//  mem_addr   out  WIDTH_ADDR  RAM address
//  mem_wdata  out  WIDTH_DATA  RAM write data
//  mem_rdata  in   WIDTH_DATA  RAM read data, valid 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; all outputs 0; last_served=B, so A wins
//    the first tie. Reset mid-operation abandons any in-flight access. No gnt, rvalid
//    or err for that access follows reset release.
//  - FSM: IDLE -> ACCESS -> (write/err: IDLE | read: RDATA -> RESP -> IDLE).
//  - IDLE (cycle T): sample req_a/req_b. Sole requester wins. If both request, the
//    requester other than last_served wins. Edge at end of T registers the winner's
//    we/addr/wdata onto mem_*. It also sets mem_en=1, sets the winner's gnt=1 and
//    updates last_served. No request: stay IDLE, outputs 0.
//  - ACCESS (T+1): mem_en and gnt high for exactly this cycle; req inputs ignored.
//    Write -> IDLE at T+2. Read -> RDATA.
//  - RDATA (T+2): mem_en=0. mem_rdata is captured into the winner's rdata register.
//  - RESP (T+3): the winner's rvalid=1 for one cycle; the rdata register holds this
//    value until the next read for that requester. Next state IDLE.
//  - Latency: gnt at T+1; read data at T+3. Throughput: one write per 2 cycles or one
//    read per 4 cycles.
//  - Requesters deassert req the cycle after seeing gnt. A req still high when the FSM
//    returns to IDLE is a new command.
//  - mem_we/mem_addr/mem_wdata hold their last value while mem_en=0.
//  - The loser of a tie keeps its req asserted and wins the next arbitration. There is
//    no starvation; worst-case wait is one foreign access.
//  - gnt_a and gnt_b are never high together; the same holds for rvalid and err.
// CONFIGURATION
//  Macro ADDR_RANGE_CHK_EN:
//   defined: a winning command with addr >= SIZE is rejected. In ACCESS, gnt and err
//     pulse together, mem_en stays 0 and no rvalid follows. Next state IDLE.
//     Round-robin is still updated.
//   undefined: no check; err_a/err_b tied 0. The address is forwarded unmodified;
//     range handling is the memory's responsibility.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> all outputs 0. First tie after release -> gnt_a.
//  2 A writes 0x5A @3 at T -> T+1: gnt_a=1, mem_en=1, mem_we=1, mem_addr=3,
//    mem_wdata=0x5A. Then A reads @3 -> gnt_a 1 cycle after req, rvalid_a=1 with
//    rdata_a=0x5A 2 cycles after gnt_a.
//  3 req_a and req_b held high for 8 commands -> grants alternate A,B,A,B.
//    No double gnt; no request is lost.
//  4 Read in flight (RDATA state): pulse rst_n=0 for 1 cycle -> no rvalid afterwards;
//    next tie goes to A.
//  5 ADDR_RANGE_CHK_EN with WIDTH_ADDR=6: A reads addr 9 -> gnt_a=err_a=1 in the same
//    cycle, mem_en=0, no rvalid_a. Without the macro, mem_addr=9 and mem_en=1.
//  6 Back-to-back writes from B only -> gnt_b every 2nd cycle.
//    mem_addr/wdata held stable between accesses.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Optional feature macro ADDR_RANGE_CHK_EN: reject winning commands whose address is >= SIZE.
module mem_rr_arbiter #(
    parameter int SIZE       = 8,
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [WIDTH_ADDR-1:0] addr_a,
    input  logic [WIDTH_DATA-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [WIDTH_DATA-1:0] rdata_a,
    output logic                  err_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [WIDTH_ADDR-1:0] addr_b,
    input  logic [WIDTH_DATA-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [WIDTH_DATA-1:0] rdata_b,
    output logic                  err_b,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    input  logic [WIDTH_DATA-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

    state_t                state, state_nxt;
    logic                  last_b, sel, grant, win_b, win_we, range_err;
    logic [WIDTH_ADDR-1:0] win_addr;
    logic [WIDTH_DATA-1:0] win_wdata;

    // Arbitration: a sole requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant     = (state == IDLE) & (req_a | req_b);
        win_b     = req_b & (~req_a | ~last_b);
        win_we    = win_b ? we_b : we_a;
        win_addr  = win_b ? addr_b : addr_a;
        win_wdata = win_b ? wdata_b : wdata_a;
    end

`ifdef ADDR_RANGE_CHK_EN
    assign range_err = 33'(win_addr) >= 33'(SIZE);
`else
    assign range_err = 1'b0;
`endif

    // Next state: reads walk through RDATA/RESP, writes and rejected commands go straight back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? ACCESS : IDLE;
            ACCESS:  state_nxt = (mem_we | err_a | err_b) ? IDLE : RDATA;
            RDATA:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered RAM command bus, grant/error/valid pulses and per-requester read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b    <= 1'b1;
            sel       <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt_a    <= grant & ~win_b;
            gnt_b    <= grant & win_b;
            err_a    <= grant & ~win_b & range_err;
            err_b    <= grant & win_b & range_err;
            mem_en   <= grant & ~range_err;
            rvalid_a <= (state == RDATA) & ~sel;
            rvalid_b <= (state == RDATA) & sel;
            if (grant) begin
                sel    <= win_b;
                last_b <= win_b;
            end
            if (grant & ~range_err) begin
                mem_we    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
            if (state == RDATA) begin
                if (sel)
                    rdata_b <= mem_rdata;
                else
                    rdata_a <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed bench with a RAM model and per-requester read-data scoreboards.
module tb_mem_rr_arbiter;
    localparam int SIZE = 8;
    localparam int WD   = 8;
    localparam int WA   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, we_a, gnt_a, rvalid_a, err_a;
    logic          req_b, we_b, gnt_b, rvalid_b, err_b;
    logic [WA-1:0] addr_a, addr_b, mem_addr;
    logic [WD-1:0] wdata_a, wdata_b, rdata_a, rdata_b, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;

    logic [WD-1:0] ram   [64];
    logic [WD-1:0] model [64];
    logic [WD-1:0] qa[$];
    logic [WD-1:0] qb[$];
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.SIZE(SIZE), .WIDTH_DATA(WD), .WIDTH_ADDR(WA)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a), .err_a(err_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b), .err_b(err_b),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM; read data is junk except the cycle after a read strobe
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr] : 8'hEE;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Exclusivity and read-data scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (gnt_a || gnt_b) chk1("gnt_excl", gnt_a & gnt_b, 1'b0);
        if (rvalid_a || rvalid_b) chk1("rvalid_excl", rvalid_a & rvalid_b, 1'b0);
        if (err_a || err_b) chk1("err_excl", err_a & err_b, 1'b0);
        if (rvalid_a) begin
            if (qa.size() == 0) chk1("rvalid_a_unexpected", rvalid_a, 1'b0);
            else chkv("rdata_a_sb", 32'(rdata_a), 32'(qa.pop_front()));
        end
        if (rvalid_b) begin
            if (qb.size() == 0) chk1("rvalid_b_unexpected", rvalid_b, 1'b0);
            else chkv("rdata_b_sb", 32'(rdata_b), 32'(qb.pop_front()));
        end
    end

    task automatic wait_gnt(input bit b, output int n);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (b ? gnt_b : gnt_a) break;
        end
        chk1("gnt_seen", b ? gnt_b : gnt_a, 1'b1);
    endtask

    // One command from an idle arbiter, checked through to completion
    task automatic cmd(input bit b, input bit we, input logic [WA-1:0] addr, input logic [WD-1:0] wd);
        int n;
        bit oob;
        logic [WD-1:0] exp;
        oob = 1'b0;
`ifdef ADDR_RANGE_CHK_EN
        oob = int'(addr) >= SIZE;
`endif
        exp = model[addr];
        if (b) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        wait_gnt(b, n);
        chkv("gnt_latency", n, 1);
        if (b) req_b = 1'b0; else req_a = 1'b0;
        chk1("err", b ? err_b : err_a, oob);
        chk1("mem_en", mem_en, !oob);
        if (!oob) begin
            chk1("mem_we", mem_we, we);
            chkv("mem_addr", 32'(mem_addr), 32'(addr));
            if (we) begin
                chkv("mem_wdata", 32'(mem_wdata), 32'(wd));
                model[addr] = wd;
            end else if (b) qb.push_back(exp);
            else qa.push_back(exp);
        end
        @(negedge clk);
        chk1("gnt_pulse", b ? gnt_b : gnt_a, 1'b0);
        chk1("mem_en_off", mem_en, 1'b0);
        if (!oob && !we) begin
            chk1("rvalid_early", b ? rvalid_b : rvalid_a, 1'b0);
            @(negedge clk);
            chk1("rvalid", b ? rvalid_b : rvalid_a, 1'b1);
            chkv("rdata", 32'(b ? rdata_b : rdata_a), 32'(exp));
            @(negedge clk);
        end
        if (!oob) begin
            chkv("mem_addr_hold", 32'(mem_addr), 32'(addr));
            if (we) chkv("mem_wdata_hold", 32'(mem_wdata), 32'(wd));
        end
    endtask

    initial begin
        int n, ng, na, nb;
        bit exp_b;
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        // Reset held 3 cycles
        repeat (3) @(negedge clk);
        chkv("rst_ctrl", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
        chkv("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
        rst_n = 1'b1;
        // Both requesters busy: A writes, B reads back what A wrote; grants alternate from A
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd0; wdata_a = 8'hA0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 6'd0;
        ng = 0; na = 0; nb = 0; exp_b = 1'b0;
        for (int c = 0; c < 80 && ng < 8; c++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                chk1("rr_order", gnt_b, exp_b);
                exp_b = !exp_b;
                ng++;
                if (gnt_a) begin
                    model[addr_a] = wdata_a;
                    na++;
                    if (na < 4) begin addr_a = 6'(na); wdata_a = 8'hA0 + 8'(na); end
                    else req_a = 1'b0;
                end else begin
                    qb.push_back(model[addr_b]);
                    nb++;
                    if (nb < 4) addr_b = 6'(nb);
                    else req_b = 1'b0;
                end
            end
        end
        chkv("rr_grants", ng, 8);
        chkv("rr_a_served", na, 4);
        chkv("rr_b_served", nb, 4);
        repeat (4) @(negedge clk);
        chkv("rr_b_drained", qb.size(), 0);
        // A write then read of 0x5A at address 3
        cmd(1'b0, 1'b1, 6'd3, 8'h5A);
        cmd(1'b0, 1'b0, 6'd3, 8'h00);
        // Reset while a read sits in RDATA: no rvalid afterwards, round-robin restarts with A
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'd3;
        wait_gnt(1'b0, n);
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chkv("midrst_ctrl", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_en}), 32'd0);
        chkv("midrst_rdata", 32'(rdata_a), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 6'd6; wdata_b = 8'h22;
        wait_gnt(1'b0, n);
        chkv("tie_a_latency", n, 1);
        chk1("tie_b_waits", gnt_b, 1'b0);
        model[5] = 8'h11;
        req_a = 1'b0;
        wait_gnt(1'b1, n);
        chkv("tie_b_latency", n, 2);
        model[6] = 8'h22;
        req_b = 1'b0;
        @(negedge clk);
        cmd(1'b1, 1'b0, 6'd5, 8'h00);
        cmd(1'b0, 1'b0, 6'd6, 8'h00);
        // Out-of-range address 9 (rejected only when the range check is built in)
        cmd(1'b0, 1'b1, 6'd9, 8'h77);
        cmd(1'b0, 1'b0, 6'd9, 8'h00);
        // Back-to-back writes from B alone
        for (int i = 0; i < 4; i++) cmd(1'b1, 1'b1, 6'(i + 1), 8'hB0 + 8'(i));
        cmd(1'b1, 1'b0, 6'd2, 8'h00);
        repeat (4) @(negedge clk);
        chkv("qa_drained", qa.size(), 0);
        chkv("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
